// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: double-buffered 12x16 FIR coefficient store.
// The host fills a shadow bank while the filter runs on the active bank.
// The active bank is replaced in one edge, and oEnAcc freezes the
// downstream stages for that cycle.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | filter runs on the active bank, host may only read
// ST_LOAD   | update session open, host writes land in the shadow bank
// ST_COMMIT | one-cycle freeze; shadow copied to active on the exit edge
module fir_coeff_bank (
  input  logic         iClk_12M,
  input  logic         iRst,
  input  logic         iCoeffUpdateFlag,
  input  logic         iCsnRam,
  input  logic         iWrnRam,
  input  logic [3:0]   iAddrRam,
  input  logic [15:0]  iWrDtRam,
  output logic [15:0]  oRdDtRam,
  output logic [191:0] oCoeffFlat,
  output logic         oEnAcc,
  output logic         oUpdBusy,
  output logic         oAddrErr
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [3:0] NUM_TAPS = 4'd12;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [15:0] shadow [12];
  logic [15:0] active [12];
  logic        wr_req;
  logic        rd_req;
  logic        addr_ok;

  assign wr_req   = ~iCsnRam & ~iWrnRam;
  assign rd_req   = ~iCsnRam &  iWrnRam;
  assign addr_ok  = (iAddrRam < NUM_TAPS);
  assign oUpdBusy = (state != ST_IDLE);

  // Next-state decode; COMMIT always lasts exactly one cycle.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:   state_nxt = iCoeffUpdateFlag ? ST_LOAD : ST_IDLE;
      ST_LOAD:   state_nxt = iCoeffUpdateFlag ? ST_LOAD : ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register and the registered freeze pulse aligned to COMMIT.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state  <= ST_IDLE;
      oEnAcc <= 1'b0;
    end else begin
      state  <= state_nxt;
      oEnAcc <= (state_nxt == ST_COMMIT);
    end
  end

  // Shadow bank: host writes only land while a session is open.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < 12; i++) shadow[i] <= '0;
    end else if ((state == ST_LOAD) && wr_req && addr_ok) begin
      shadow[iAddrRam] <= iWrDtRam;
    end
  end

  // Active bank: whole-set copy on the COMMIT exit edge, never partial.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < 12; i++) active[i] <= '0;
    end else if (state == ST_COMMIT) begin
      for (int i = 0; i < 12; i++) active[i] <= shadow[i];
    end
  end

  // Registered readback of the shadow bank; illegal addresses read as 0.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      oRdDtRam <= '0;
    end else if (rd_req) begin
      oRdDtRam <= addr_ok ? shadow[iAddrRam] : 16'h0000;
    end
  end

  // Sticky illegal-address flag, scoped to one update session.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      oAddrErr <= 1'b0;
    end else if ((state == ST_IDLE) && (state_nxt == ST_LOAD)) begin
      oAddrErr <= 1'b0;
    end else if ((state == ST_LOAD) && wr_req && !addr_ok) begin
      oAddrErr <= 1'b1;
    end
  end

  // Flatten the active bank for the multiply/add/shift stages.
  always_comb begin
    oCoeffFlat = '0;
    for (int i = 0; i < 12; i++) oCoeffFlat[16*i +: 16] = active[i];
  end

endmodule

// File: tb/tb_fir_coeff_bank.sv
module tb_fir_coeff_bank;

  logic         iClk_12M = 1'b0;
  logic         iRst = 1'b1;
  logic         iCoeffUpdateFlag = 1'b0;
  logic         iCsnRam = 1'b1;
  logic         iWrnRam = 1'b1;
  logic [3:0]   iAddrRam = '0;
  logic [15:0]  iWrDtRam = '0;
  logic [15:0]  oRdDtRam;
  logic [191:0] oCoeffFlat;
  logic         oEnAcc;
  logic         oUpdBusy;
  logic         oAddrErr;

  int n_vec = 0;
  int n_bad = 0;

  fir_coeff_bank dut (
    .iClk_12M(iClk_12M), .iRst(iRst), .iCoeffUpdateFlag(iCoeffUpdateFlag),
    .iCsnRam(iCsnRam), .iWrnRam(iWrnRam), .iAddrRam(iAddrRam),
    .iWrDtRam(iWrDtRam), .oRdDtRam(oRdDtRam), .oCoeffFlat(oCoeffFlat),
    .oEnAcc(oEnAcc), .oUpdBusy(oUpdBusy), .oAddrErr(oAddrErr)
  );

  always #5 iClk_12M = ~iClk_12M;

  // Behavioural model: a session is "open" or "committing", tap memories
  // are plain arrays, and commit is a whole-array copy.
  logic [15:0] m_sh  [12];
  logic [15:0] m_act [12];
  logic [15:0] m_rd;
  bit          m_open, m_committing, m_err;

  function automatic logic [191:0] m_flat();
    logic [191:0] f;
    for (int i = 0; i < 12; i++) f[16*i +: 16] = m_act[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin m_sh[i] = 0; m_act[i] = 0; end
    m_rd = 0; m_open = 0; m_committing = 0; m_err = 0;
  endtask

  task automatic model_step(input bit flag, input bit csn, input bit wrn,
                            input int addr, input logic [15:0] data);
    if (!csn && wrn) m_rd = (addr < 12) ? m_sh[addr] : 16'h0;
    if (m_committing) begin
      for (int i = 0; i < 12; i++) m_act[i] = m_sh[i];
      m_committing = 0;
    end else if (m_open) begin
      if (!csn && !wrn) begin
        if (addr < 12) m_sh[addr] = data;
        else m_err = 1;
      end
      if (!flag) begin m_open = 0; m_committing = 1; end
    end else if (flag) begin
      m_open = 1; m_err = 0;
    end
  endtask

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("rd",    192'(oRdDtRam), 192'(m_rd));
    chk("coeff", oCoeffFlat, m_flat());
    chk("enacc", 192'(oEnAcc), 192'(m_committing));
    chk("busy",  192'(oUpdBusy), 192'(m_open || m_committing));
    chk("err",   192'(oAddrErr), 192'(m_err));
  endtask

  // One clock: drive, clock edge, advance model, sample 1 time unit later.
  task automatic cyc(input bit flag, input bit csn, input bit wrn,
                     input int addr, input logic [15:0] data);
    iCoeffUpdateFlag = flag; iCsnRam = csn; iWrnRam = wrn;
    iAddrRam = 4'(addr); iWrDtRam = data;
    @(posedge iClk_12M);
    model_step(flag, csn, wrn, addr, data);
    #1;
    check_model();
  endtask

  typedef struct {
    bit flag; bit csn; bit wrn; int addr; logic [15:0] data;
    logic [15:0] e_rd; bit e_busy; bit e_en; bit e_err;
    logic [15:0] e_t0; logic [15:0] e_t1;
  } vec_t;

  vec_t tbl [12];
  bit   en_seen;

  initial begin
    // flag csn wrn addr data | rd busy en err tap0 tap1
    tbl[0]  = '{0,0,1, 3,16'h0000, 16'h0000,0,0,0, 16'h0,16'h0};
    tbl[1]  = '{1,1,1, 0,16'h0000, 16'h0000,1,0,0, 16'h0,16'h0};
    tbl[2]  = '{1,0,0, 0,16'h0001, 16'h0000,1,0,0, 16'h0,16'h0};
    tbl[3]  = '{1,0,0,13,16'h1234, 16'h0000,1,0,1, 16'h0,16'h0};
    tbl[4]  = '{1,0,1, 0,16'h0000, 16'h0001,1,0,1, 16'h0,16'h0};
    tbl[5]  = '{0,0,0, 1,16'h0002, 16'h0001,1,1,1, 16'h0,16'h0};
    tbl[6]  = '{1,0,1, 1,16'h0000, 16'h0002,0,0,1, 16'h1,16'h2};
    tbl[7]  = '{1,1,1, 0,16'h0000, 16'h0002,1,0,0, 16'h1,16'h2};
    tbl[8]  = '{0,1,1, 0,16'h0000, 16'h0002,1,1,0, 16'h1,16'h2};
    tbl[9]  = '{0,0,1,13,16'h0000, 16'h0000,0,0,0, 16'h1,16'h2};
    tbl[10] = '{0,0,0, 0,16'h7FFF, 16'h0000,0,0,0, 16'h1,16'h2};
    tbl[11] = '{0,0,1, 0,16'h0000, 16'h0001,0,0,0, 16'h1,16'h2};

    model_reset();
    #2;
    check_model();
    @(negedge iClk_12M);
    iRst = 1'b0;

    for (int a = 0; a < 12; a++) cyc(0, 0, 1, a, 16'h0);

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].flag, tbl[i].csn, tbl[i].wrn, tbl[i].addr, tbl[i].data);
      chk("tbl_rd",   192'(oRdDtRam), 192'(tbl[i].e_rd));
      chk("tbl_busy", 192'(oUpdBusy), 192'(tbl[i].e_busy));
      chk("tbl_en",   192'(oEnAcc),   192'(tbl[i].e_en));
      chk("tbl_err",  192'(oAddrErr), 192'(tbl[i].e_err));
      chk("tbl_tap0", 192'(oCoeffFlat[15:0]),  192'(tbl[i].e_t0));
      chk("tbl_tap1", 192'(oCoeffFlat[31:16]), 192'(tbl[i].e_t1));
    end

    // Full session: taps 0..11 = 1..12, one-cycle oEnAcc, atomic switch.
    cyc(1, 1, 1, 0, 16'h0);
    for (int a = 0; a < 12; a++) cyc(1, 0, 0, a, 16'(a + 1));
    cyc(0, 1, 1, 0, 16'h0);
    chk("full_en_hi", 192'(oEnAcc), 192'(1));
    cyc(0, 1, 1, 0, 16'h0);
    chk("full_en_lo", 192'(oEnAcc), 192'(0));
    for (int a = 0; a < 12; a++)
      chk("full_tap", 192'(oCoeffFlat[16*a +: 16]), 192'(a + 1));

    // Partial session: only tap 5 changes.
    cyc(1, 1, 1, 0, 16'h0);
    cyc(0, 0, 0, 5, 16'hFFF0);
    cyc(0, 1, 1, 0, 16'h0);
    for (int a = 0; a < 12; a++)
      chk("part_tap", 192'(oCoeffFlat[16*a +: 16]), (a == 5) ? 192'(16'hFFF0) : 192'(a + 1));

    // Reset in the middle of LOAD: outputs clear asynchronously, no commit.
    cyc(1, 1, 1, 0, 16'h0);
    cyc(1, 0, 0, 0, 16'h0042);
    #2;
    iRst = 1'b1;
    #1;
    model_reset();
    check_model();
    @(negedge iClk_12M);
    iRst = 1'b0;
    iCoeffUpdateFlag = 1'b0;
    en_seen = 0;
    cyc(0, 0, 1, 0, 16'h0);
    en_seen |= oEnAcc;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1, 1, 0, 16'h0);
      en_seen |= oEnAcc;
    end
    chk("rst_no_commit_pulse", 192'(en_seen), 192'(0));

    // Randomized traffic against the model.
    begin
      bit flag = 0;
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 7) == 0) flag = ~flag;
        cyc(flag, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), 16'($urandom));
      end
      for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 16'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_coeff_bank.md
# fir_coeff_bank

Coefficient storage and update controller sitting directly upstream of the transposed multiply/add/shift stages of the FIR datapath. It holds 12 signed 16-bit taps (four 3-tap groups, one group per multiply/add/shift stage) in a double-buffered register file. A host loads taps into a shadow bank through a simple RAM-style port while the filter keeps running on the active bank. The block then commits the shadow bank atomically and generates the `oEnAcc` freeze pulse consumed by the downstream stages.

## Interface
Parameters: none; tap count (12) and width (16) are fixed.
- `iClk_12M` input 1 — 12 MHz system clock; all state updates on its rising edge.
- `iRst` input 1 — asynchronous, active-high reset.
- `iCoeffUpdateFlag` input 1 — level; high requests/holds update mode, falling edge triggers commit.
- `iCsnRam` input 1 — active-low chip select for the host port.
- `iWrnRam` input 1 — 0 = write, 1 = read (qualified by `iCsnRam`=0).
- `iAddrRam` input 4 — tap address; 0–11 are valid, 12–15 are illegal.
- `iWrDtRam` input 16 — signed tap write data.
- `oRdDtRam` output 16 — registered shadow-bank read data.
- `oCoeffFlat` output 192 — active bank; tap n at bits [16n+15:16n]; group g = taps 3g..3g+2 drive iCoeff1..3 of stage g.
- `oEnAcc` output 1 — registered; 1 freezes downstream stages (they advance when 0).
- `oUpdBusy` output 1 — high whenever the FSM is not IDLE.
- `oAddrErr` output 1 — sticky illegal-write flag for the current update session.

## Operation
- FSM states: IDLE, LOAD, COMMIT.
  - IDLE → LOAD when `iCoeffUpdateFlag`=1.
  - LOAD → COMMIT when `iCoeffUpdateFlag`=0.
  - COMMIT → IDLE unconditionally, one cycle later.
- Writes: accepted only while the state register is LOAD, with `iCsnRam`=0, `iWrnRam`=0 and `iAddrRam`<12; the shadow entry is updated at that edge.
  - Writes in IDLE or COMMIT are silently dropped and do not set `oAddrErr`.
  - A LOAD write with `iAddrRam`≥12 is dropped and sets `oAddrErr`.
- `oAddrErr`:
  - Cleared on the IDLE→LOAD transition.
  - Otherwise holds its value until the next update session or reset.
- Reads: allowed in any state when `iCsnRam`=0 and `iWrnRam`=1.
  - `oRdDtRam` ← shadow[`iAddrRam`] at the next edge; returns 0 for addresses ≥12.
  - `oRdDtRam` holds its last value when no read is issued.
- Shadow contents persist across sessions. A session that writes only some taps commits the untouched taps with their previous shadow values.
- COMMIT: all 12 active registers ← shadow in a single edge (the COMMIT→IDLE edge), so `oCoeffFlat` never shows a partially updated set.
- Active bank changes only at commit; `oCoeffFlat` is stable during LOAD.
- `oEnAcc` ← (next state == COMMIT), registered, so it is high exactly during the COMMIT cycle. This freezes the downstream shift chain for the cycle in which coefficients switch.
- `oUpdBusy` is a decode of the state register.

## Timing
- Reset (async assert, sync to state only via flops):
  - Registers: shadow and active all 0; state IDLE.
  - Outputs: `oCoeffFlat`=0, `oRdDtRam`=0, `oEnAcc`=0, `oUpdBusy`=0, `oAddrErr`=0.
- Reset during LOAD or COMMIT: everything returns to reset values immediately and no commit occurs.
- Update sequence, with the flag sampled high at edge N and low at edge M (M>N):
  - State is LOAD after edge N; `oUpdBusy`=1 from N.
  - A write present in the cycle before edge M is still accepted, because the state is LOAD during that cycle.
  - After edge M: state COMMIT, `oEnAcc`=1.
  - After edge M+1: `oCoeffFlat` updated (including the last write), state IDLE, `oEnAcc`=0, `oUpdBusy`=0.
- Write-to-readback latency: a read issued the cycle after a write returns the new value.
- Simultaneous read and write are impossible by encoding (`iWrnRam` selects one).
- Flag re-raised during COMMIT is ignored for that cycle. If still high in IDLE, a new LOAD starts at the next edge.
- Flag held high forever keeps LOAD indefinitely; the active bank is unchanged.

## Test plan
- Reset, then read addresses 0–11 → `oRdDtRam`=0 each time. Check `oCoeffFlat`=0, `oEnAcc`=0, `oUpdBusy`=0.
- Flag high, write taps 0..11 = 16'h0001..16'h000C, flag low → `oEnAcc`=1 for exactly one cycle, then `oCoeffFlat` tap n = n+1 one edge later. `oCoeffFlat` unchanged throughout LOAD.
- Second session writes only tap 5 = 16'hFFF0 (-16) → after commit, tap 5 = -16 and all other taps retain 1..12.
- Write addr 13 data 16'h1234 in LOAD → `oAddrErr`=1, shadow unchanged, commit still occurs. The next session clears `oAddrErr` at LOAD entry.
- Writes while IDLE (addr 0, 16'h7FFF) → dropped. Readback and `oCoeffFlat` are unchanged, `oAddrErr`=0.
- Assert `iRst` mid-LOAD after writing tap 0 = 16'h0042 → all outputs 0 immediately. After release, state IDLE, tap 0 readback = 0, and `oEnAcc` never pulses.
